// File: rtl/hc194_deser_if.sv
// Serial-link receive bundle for hc194_deser: strobed bit stream in, held word plus status out.
// The master side is the transmitter/consumer; the slave side is the receiver.
interface hc194_deser_if #(
    parameter int WIDTH = 4
);
    logic             SIN;
    logic             SEN;
    logic             SYNC;
    logic             DIR;
    logic             ACK;
    logic             ERR_CLR;
    logic [0:WIDTH-1] Q;
    logic             QV;
    logic             BUSY;
    logic             OVR;
    logic             FERR;

    modport master (
        output SIN, SEN, SYNC, DIR, ACK, ERR_CLR,
        input  Q, QV, BUSY, OVR, FERR
    );

    modport slave (
        input  SIN, SEN, SYNC, DIR, ACK, ERR_CLR,
        output Q, QV, BUSY, OVR, FERR
    );
endinterface

// File: rtl/hc194_deser.sv
// Receive end of the 194-style shift-register link: reassembles WIDTH-bit words in either
// shift order and holds them behind a valid/acknowledge handshake with overrun/framing flags.
module hc194_deser #(
    parameter int WIDTH = 4
) (
    input logic          CP,
    input logic          MR,
    hc194_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state_q, state_d;
    logic [0:WIDTH-1] sh_q, sh_d;
    logic [0:WIDTH-1] q_q, q_d;
    logic [0:WIDTH-1] sh_next;
    logic [CW-1:0]    count_q, count_d;
    logic             dir_l_q, dir_l_d;
    logic             qv_q, qv_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             shift_dir;
    logic             complete;
    logic             ovr_set;
    logic             ferr_set;

    // dir=0 mirrors a right-shifting source (new bit enters index 0), dir=1 a left-shifting one.
    function automatic logic [0:WIDTH-1] shift_in(input logic [0:WIDTH-1] cur,
                                                  input logic             din,
                                                  input logic             dir);
        logic [0:WIDTH-1] nxt;
        if (dir) begin
            nxt = {cur[1:WIDTH-1], din};
        end else begin
            nxt = {din, cur[0:WIDTH-2]};
        end
        return nxt;
    endfunction

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        q_d      = q_q;
        count_d  = count_q;
        dir_l_d  = dir_l_q;
        qv_d     = qv_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        complete = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;

        // A frame-start bit takes its order from DIR directly; later bits use the latched order.
        shift_dir = (state_q == IDLE || bus.SYNC) ? bus.DIR : dir_l_q;
        sh_next   = shift_in(sh_q, bus.SIN, shift_dir);

        if (bus.ACK) begin
            qv_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.SEN && bus.SYNC) begin
                    dir_l_d = bus.DIR;
                    sh_d    = sh_next;
                    count_d = ONE;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.SEN) begin
                    sh_d = sh_next;
                    if (bus.SYNC) begin
                        ferr_set = 1'b1;
                        dir_l_d  = bus.DIR;
                        count_d  = ONE;
                    end else if (count_q == LAST) begin
                        complete = 1'b1;
                        count_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An acknowledge in the completion cycle frees the holding register just in time.
        if (complete) begin
            if (qv_q && !bus.ACK) begin
                ovr_set = 1'b1;
            end else begin
                q_d  = sh_next;
                qv_d = 1'b1;
            end
        end

        if (bus.ERR_CLR) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q <= IDLE;
            sh_q    <= '0;
            q_q     <= '0;
            count_q <= '0;
            dir_l_q <= 1'b0;
            qv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            count_q <= count_d;
            dir_l_q <= dir_l_d;
            qv_q    <= qv_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.QV   = qv_q;
    assign bus.BUSY = (state_q == RECV);
    assign bus.OVR  = ovr_q;
    assign bus.FERR = ferr_q;
endmodule
